// File: rtl/dotprod_stream_ctrl.sv
// ---------------------------------------------------------------------------
// dotprod_stream_ctrl
//
// Operand feeder and result collector for an external combinational
// dot-product datapath. Element pairs (a_i, b_i) arrive over a valid/ready
// handshake and are packed into two LEN-entry vectors. Once a vector closes
// (in_last, or the LEN-th pair), the packed vectors are held stable for
// CALC_CYC cycles while the multiply/add tree settles. The N-bit result is
// then captured and offered over a valid/ready output handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   element pair valid
//   in_ready   block can accept an element pair (high only while filling)
//   in_a/in_b  elements of vectors A and B
//   in_last    final pair of a vector (may arrive before LEN pairs)
//   vec_a/b    registered packed vectors to the dot-product instance
//   dp_result  combinational result from the dot-product instance
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   captured dot product (N bits, modulo 2^N)
//   out_len    number of elements loaded for this result
// ---------------------------------------------------------------------------
module dotprod_stream_ctrl #(
    parameter int N        = 32,
    parameter int LEN      = 4,
    parameter int CALC_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_a,
    input  logic [N-1:0]          in_b,
    input  logic                  in_last,
    output logic [N-1:0]          vec_a [LEN-1:0],
    output logic [N-1:0]          vec_b [LEN-1:0],
    input  logic [N-1:0]          dp_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_data,
    output logic [$clog2(LEN):0]  out_len
);

    // count must reach LEN (one past the last slot) so out_len = count+1 fits
    localparam int CW = $clog2(LEN) + 1;
    localparam int KW = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(LEN - 1);
    localparam logic [KW-1:0] CALC_LAST = KW'(CALC_CYC - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   count_r;
    logic [KW-1:0]   calc_cnt_r;
    logic [N-1:0]    vec_a_r [LEN-1:0];
    logic [N-1:0]    vec_b_r [LEN-1:0];
    logic [N-1:0]    out_data_r;
    logic [CW-1:0]   out_len_r;

    logic            accept_s;
    logic            close_s;
    logic            calc_done_s;
    logic            out_fire_s;

    assign in_ready  = (state_r == FILL);
    assign out_valid = (state_r == OUT);
    assign vec_a     = vec_a_r;
    assign vec_b     = vec_b_r;
    assign out_data  = out_data_r;
    assign out_len   = out_len_r;

    // Next-state and handshake decode from the registered state
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        close_s     = 1'b0;
        calc_done_s = 1'b0;
        out_fire_s  = 1'b0;
        case (state_r)
            FILL: begin
                accept_s = in_valid;
                // vector closes on in_last or on the slot that fills it
                if (in_valid && (in_last || (count_r == LAST_IDX))) begin
                    close_s     = 1'b1;
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            CALC: begin
                if (calc_cnt_r == CALC_LAST) begin
                    calc_done_s = 1'b1;
                    state_nxt_s = OUT;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_fire_s  = 1'b1;
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fill counter, settle counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= '0;
            calc_cnt_r <= '0;
            out_data_r <= '0;
            out_len_r  <= '0;
        end else begin
            if (out_fire_s) begin
                count_r <= '0;
            end else if (accept_s) begin
                count_r <= count_r + CW'(1);
            end else begin
                count_r <= count_r;
            end

            if (close_s) begin
                out_len_r <= count_r + CW'(1);
            end else begin
                out_len_r <= out_len_r;
            end

            if (state_r == CALC) begin
                if (calc_done_s) begin
                    calc_cnt_r <= '0;
                end else begin
                    calc_cnt_r <= calc_cnt_r + KW'(1);
                end
            end else begin
                calc_cnt_r <= '0;
            end

            if (calc_done_s) begin
                out_data_r <= dp_result;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    // Vector slots: written on accept, cleared together when the result leaves
    // so that unused slots of a short vector contribute zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++) begin
                vec_a_r[i] <= '0;
                vec_b_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LEN; i++) begin
                if (out_fire_s) begin
                    vec_a_r[i] <= '0;
                    vec_b_r[i] <= '0;
                end else if (accept_s && (count_r == CW'(i))) begin
                    vec_a_r[i] <= in_a;
                    vec_b_r[i] <= in_b;
                end else begin
                    vec_a_r[i] <= vec_a_r[i];
                    vec_b_r[i] <= vec_b_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_dotprod_stream_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for dotprod_stream_ctrl. Two instances: LEN=4/CALC_CYC=1 for the
// main scenarios and random traffic, LEN=4/CALC_CYC=3 for settle latency.
// The external dot-product array is stood in for by a combinational sum.
// ---------------------------------------------------------------------------
module tb_dotprod_stream_ctrl;

    localparam int LEN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // instance 1 (CALC_CYC = 1)
    logic        in_valid, in_ready, in_last, out_valid, out_ready;
    logic [31:0] in_a, in_b, dp_result, out_data;
    logic [2:0]  out_len;
    logic [31:0] vec_a [LEN-1:0];
    logic [31:0] vec_b [LEN-1:0];

    // instance 2 (CALC_CYC = 3)
    logic        c3_in_valid, c3_in_ready, c3_in_last, c3_out_valid, c3_out_ready;
    logic [31:0] c3_in_a, c3_in_b, c3_dp_result, c3_out_data;
    logic [2:0]  c3_out_len;
    logic [31:0] c3_vec_a [LEN-1:0];
    logic [31:0] c3_vec_b [LEN-1:0];

    dotprod_stream_ctrl #(.N(32), .LEN(LEN), .CALC_CYC(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .vec_a(vec_a), .vec_b(vec_b), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_len(out_len)
    );

    dotprod_stream_ctrl #(.N(32), .LEN(LEN), .CALC_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c3_in_valid), .in_ready(c3_in_ready), .in_a(c3_in_a),
        .in_b(c3_in_b), .in_last(c3_in_last), .vec_a(c3_vec_a), .vec_b(c3_vec_b),
        .dp_result(c3_dp_result), .out_valid(c3_out_valid),
        .out_ready(c3_out_ready), .out_data(c3_out_data), .out_len(c3_out_len)
    );

    // external dot-product stand-ins (modulo 2^32)
    always_comb begin
        dp_result = 32'd0;
        for (int i = 0; i < LEN; i++) dp_result = dp_result + vec_a[i] * vec_b[i];
    end
    always_comb begin
        c3_dp_result = 32'd0;
        for (int i = 0; i < LEN; i++) c3_dp_result = c3_dp_result + c3_vec_a[i] * c3_vec_b[i];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // output transfers of instance 1, recorded away from the active edge
    logic [34:0] got_q [$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_len, out_data});
    end

    typedef struct packed {
        logic [LEN-1:0][31:0] a;
        logic [LEN-1:0][31:0] b;
        logic [2:0]           nel;
        logic [31:0]          exp_data;
        logic [2:0]           exp_len;
    } vec_t;

    vec_t tbl [5];

    task automatic set_vec(input int k,
                           input logic [31:0] a0, a1, a2, a3,
                           input logic [31:0] b0, b1, b2, b3,
                           input int nel, input logic [31:0] ed, input int el);
        tbl[k].a[0] = a0; tbl[k].a[1] = a1; tbl[k].a[2] = a2; tbl[k].a[3] = a3;
        tbl[k].b[0] = b0; tbl[k].b[1] = b1; tbl[k].b[2] = b2; tbl[k].b[3] = b3;
        tbl[k].nel = 3'(nel);
        tbl[k].exp_data = ed;
        tbl[k].exp_len = 3'(el);
    endtask

    // present one pair to instance 1 and hold it until accepted (bounded)
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
        int k;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 100) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // one table entry through instance 1 with result held until checked
    task automatic run_vec(input int k);
        int lat;
        logic [31:0] ev;
        out_ready = 1'b0;
        for (int i = 0; i < int'(tbl[k].nel); i++)
            send_pair(tbl[k].a[i], tbl[k].b[i], (i == int'(tbl[k].nel) - 1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", k), 64'(lat), 64'd1);
        chk($sformatf("v%0d_out_data", k), 64'(out_data), 64'(tbl[k].exp_data));
        chk($sformatf("v%0d_out_len", k), 64'(out_len), 64'(tbl[k].exp_len));
        chk($sformatf("v%0d_in_ready_busy", k), 64'(in_ready), 64'd0);
        for (int i = 0; i < LEN; i++) begin
            ev = (i < int'(tbl[k].nel)) ? tbl[k].a[i] : 32'd0;
            chk($sformatf("v%0d_vec_a%0d", k, i), 64'(vec_a[i]), 64'(ev));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_out_valid_drop", k), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d_in_ready_back", k), 64'(in_ready), 64'd1);
        chk($sformatf("v%0d_vec_cleared", k), 64'(vec_a[0]), 64'd0);
    endtask

    // behavioural model for random traffic on instance 1
    logic [31:0] m_a [$];
    logic [31:0] m_b [$];
    int          m_calc_left;
    bit          m_pend;
    logic [31:0] m_data;
    int          m_len;

    initial begin
        int lat;
        logic [31:0] acc;

        set_vec(0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 4, 32'd70, 4);
        set_vec(1, 32'd3, 32'd4, 32'd0, 32'd0, 32'd10, 32'd10, 32'd0, 32'd0, 2, 32'd70, 2);
        set_vec(2, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
                   32'd1, 32'd1, 32'd0, 32'd0, 4, 32'h0000_0000, 4);
        set_vec(3, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,
                   32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1, 32'd1, 1);
        set_vec(4, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 4, 32'd8, 4);

        in_valid = 1'b0; in_last = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
        c3_in_valid = 1'b0; c3_in_last = 1'b0; c3_in_a = 32'd0; c3_in_b = 32'd0;
        c3_out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_len", 64'(out_len), 64'd0);
        chk("rst_vec_b3", 64'(vec_b[3]), 64'd0);
        chk("rst3_in_ready", 64'(c3_in_ready), 64'd1);

        // table: basic, early last (slots 2,3 cleared), wrap, single element
        for (int k = 0; k < 4; k++) run_vec(k);

        // output backpressure with ignored input pulses
        out_ready = 1'b0;
        for (int i = 0; i < LEN; i++) send_pair(tbl[0].a[i], tbl[0].b[i], (i == LEN - 1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got_q.delete();
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; in_a = 32'd55; in_b = 32'd55; in_last = 1'b1;
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data", 64'(out_data), 64'd70);
            chk("bp_out_len", 64'(out_len), 64'd4);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_one_transfer", 64'(got_q.size()), 64'd1);
        chk("bp_out_valid_low", 64'(out_valid), 64'd0);
        // ignored pulses must not have loaded anything
        run_vec(1);

        // missing in_last: 5 pairs then a closing 6th
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_pair(32'(i + 1), (i == 4) ? 32'd2 : 32'd1, 1'b0);
        send_pair(32'd3, 32'd3, 1'b1);
        lat = 0;
        while (got_q.size() < 2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("nolast_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            chk("nolast_first", 64'(got_q[0]), 64'({3'd4, 32'd10}));
            chk("nolast_second", 64'(got_q[1]), 64'({3'd2, 32'd19}));
        end
        out_ready = 1'b0;

        // CALC_CYC=3 with in_valid toggling; gap cycles carry garbage
        for (int i = 0; i < LEN; i++) begin
            c3_in_valid = 1'b1; c3_in_a = 32'(i + 1); c3_in_b = 32'(i + 5);
            c3_in_last = (i == LEN - 1);
            @(posedge clk); #1;
            c3_in_valid = 1'b0; c3_in_a = 32'd99; c3_in_b = 32'd99; c3_in_last = 1'b1;
            if (i < LEN - 1) begin
                @(posedge clk); #1;
            end
        end
        c3_in_last = 1'b0;
        lat = 0;
        while (!c3_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("c3_latency", 64'(lat), 64'd3);
        chk("c3_out_data", 64'(c3_out_data), 64'd70);
        chk("c3_out_len", 64'(c3_out_len), 64'd4);
        c3_out_ready = 1'b1;
        @(posedge clk); #1;
        c3_out_ready = 1'b0;
        chk("c3_out_valid_drop", 64'(c3_out_valid), 64'd0);

        // reset mid-fill
        send_pair(32'd7, 32'd9, 1'b0);
        send_pair(32'd7, 32'd9, 1'b0);
        chk("mid_vec_a0_loaded", 64'(vec_a[0]), 64'd7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec_a0", 64'(vec_a[0]), 64'd0);
        chk("mid_rst_vec_b1", 64'(vec_b[1]), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_out_len", 64'(out_len), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        #6;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        run_vec(4);

        // random traffic against the model
        m_a.delete(); m_b.delete();
        m_calc_left = 0; m_pend = 1'b0; m_data = 32'd0; m_len = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_last   = ($urandom_range(0, 3) == 0);
            in_a      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
            in_b      = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            if (m_calc_left == 0 && !m_pend) begin
                if (in_valid) begin
                    m_a.push_back(in_a);
                    m_b.push_back(in_b);
                    if (in_last || m_a.size() == LEN) begin
                        acc = 32'd0;
                        foreach (m_a[j]) acc = acc + m_a[j] * m_b[j];
                        m_data = acc;
                        m_len  = m_a.size();
                        m_a.delete(); m_b.delete();
                        m_calc_left = 1;
                    end
                end
            end else if (m_calc_left > 0) begin
                m_calc_left--;
                if (m_calc_left == 0) m_pend = 1'b1;
            end else if (out_ready) begin
                m_pend = 1'b0;
            end
            #1;
            chk("rnd_in_ready", 64'(in_ready), 64'(m_calc_left == 0 && !m_pend));
            chk("rnd_out_valid", 64'(out_valid), 64'(m_pend));
            if (m_pend) begin
                chk("rnd_out_data", 64'(out_data), 64'(m_data));
                chk("rnd_out_len", 64'(out_len), 64'(m_len));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
